// File: rtl/pwm_carrier_maskgen_pkg.sv
// Shared types for the PWM carrier / mask-event generator.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package pwm_carrier_maskgen_pkg;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [1:0] {
        CARRIER_UP     = 2'd0,
        CARRIER_DOWN   = 2'd1,
        CARRIER_UPDOWN = 2'd2
    } _carrier_mode;

    typedef enum logic [1:0] {
        MASK_NONE   = 2'd0,
        MASK_ZERO   = 2'd1,
        MASK_PERIOD = 2'd2,
        MASK_BOTH   = 2'd3
    } _mask_mode;

    function automatic logic mask_sel_zero(input _mask_mode m);
        return (m == MASK_ZERO) || (m == MASK_BOTH);
    endfunction

    function automatic logic mask_sel_period(input _mask_mode m);
        return (m == MASK_PERIOD) || (m == MASK_BOTH);
    endfunction

endpackage

// File: rtl/pwm_carrier_maskgen_if.sv
// Control/status bundle between the carrier generator and its surroundings.
// mask_prescale exists only when PWM_MASK_PRESCALE_EN is defined.
interface pwm_carrier_maskgen_if #(
    parameter int COUNT_WIDTH = `PWMCOUNT_WIDTH
);
    import pwm_carrier_maskgen_pkg::*;

    _pwm_onoff              pwm_onoff;
    _carrier_mode           carrier_mode;
    _mask_mode              mask_mode;
    logic [COUNT_WIDTH-1:0] period;
`ifdef PWM_MASK_PRESCALE_EN
    logic [3:0]             mask_prescale;
`endif
    logic [COUNT_WIDTH-1:0] count;
    logic                   dir_down;
    logic                   zero_evt;
    logic                   period_evt;
    logic                   maskevent;

    modport master (
        output pwm_onoff, carrier_mode, mask_mode, period,
`ifdef PWM_MASK_PRESCALE_EN
        output mask_prescale,
`endif
        input  count, dir_down, zero_evt, period_evt, maskevent
    );

    modport slave (
        input  pwm_onoff, carrier_mode, mask_mode, period,
`ifdef PWM_MASK_PRESCALE_EN
        input  mask_prescale,
`endif
        output count, dir_down, zero_evt, period_evt, maskevent
    );

endinterface

// File: rtl/pwm_mask_prescaler.sv
// Qualified-event decimator: fires on every (prescale+1)th event.
// Compiled only when PWM_MASK_PRESCALE_EN is defined.
`ifdef PWM_MASK_PRESCALE_EN
module pwm_mask_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       evt_i,
    input  logic [3:0] prescale_i,
    output logic       fire_o
);
    logic [3:0] cnt_q, cnt_d;

    // cnt_q holds the number of events already swallowed since the last fire
    assign fire_o = evt_i && (cnt_q == prescale_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || fire_o) begin
            cnt_d = 4'd0;
        end else if (evt_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`endif

// File: rtl/pwm_carrier_maskgen.sv
// Carrier counter and shadow-register mask strobe generator for one PWM channel.
// Optional maskevent decimation is built when PWM_MASK_PRESCALE_EN is defined.
module pwm_carrier_maskgen
    import pwm_carrier_maskgen_pkg::*;
#(
    parameter int COUNT_WIDTH = `PWMCOUNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_carrier_maskgen_if.slave bus
);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   dir_q, dir_d;
    _carrier_mode           mode_q, mode_d;
    logic                   armed_q;
    logic [COUNT_WIDTH-1:0] period;
    logic                   running;
    logic                   zero_evt;
    logic                   period_evt;
    logic                   qual_evt;

    assign period = bus.period;

    // armed_q keeps the first edge after reset release in the halted behaviour
    assign running    = (bus.pwm_onoff == PWM_ON) && armed_q;
    assign zero_evt   = running && (count_q == '0);
    assign period_evt = running && (count_q >= period);
    assign qual_evt   = (mask_sel_zero(bus.mask_mode) && zero_evt) ||
                        (mask_sel_period(bus.mask_mode) && period_evt);

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        if (!running) begin
            mode_d  = bus.carrier_mode;
            dir_d   = (bus.carrier_mode == CARRIER_DOWN);
            count_d = (bus.carrier_mode == CARRIER_DOWN) ? period : '0;
        end else begin
            case (mode_q)
                CARRIER_DOWN: begin
                    count_d = (count_q == '0) ? period : (count_q - CNT_ONE);
                end
                CARRIER_UPDOWN: begin
                    if (!dir_q) begin
                        if (count_q >= period) begin
                            dir_d   = 1'b1;
                            count_d = (period == '0) ? '0 : (period - CNT_ONE);
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end else begin
                        if (count_q == '0) begin
                            dir_d   = 1'b0;
                            count_d = (period == '0) ? '0 : CNT_ONE;
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    count_d = (count_q >= period) ? '0 : (count_q + CNT_ONE);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            mode_q  <= CARRIER_UP;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            armed_q <= 1'b1;
        end
    end

    assign bus.count      = count_q;
    assign bus.dir_down   = dir_q;
    assign bus.zero_evt   = zero_evt;
    assign bus.period_evt = period_evt;

`ifdef PWM_MASK_PRESCALE_EN
    logic mask_fire;

    pwm_mask_prescaler u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (!running),
        .evt_i      (qual_evt),
        .prescale_i (bus.mask_prescale),
        .fire_o     (mask_fire)
    );

    assign bus.maskevent = mask_fire;
`else
    assign bus.maskevent = qual_evt;
`endif

endmodule

// File: tb/tb_pwm_carrier_maskgen.sv
// Self-checking bench for pwm_carrier_maskgen with a rule-level reference model
// and a behavioural shadow period register feeding the period input.
module tb_pwm_carrier_maskgen;
    import pwm_carrier_maskgen_pkg::*;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pwm_carrier_maskgen_if #(.COUNT_WIDTH(W)) bus();
    pwm_carrier_maskgen #(.COUNT_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    _pwm_onoff    drv_on;
    _carrier_mode drv_cm;
    _mask_mode    drv_mm;
    int           drv_psc;
    int           sh_out;
    int           sh_wr;

    int           m_count;
    int           m_psc;
    bit           m_dir;
    bit           m_armed;
    _carrier_mode m_mode;

    bit           e_run, e_qual, e_zero, e_per, e_mask;
    logic [W+3:0] e_vec;

    function automatic logic [W+3:0] got_vec();
        return {bus.count, bus.dir_down, bus.zero_evt, bus.period_evt, bus.maskevent};
    endfunction

    function automatic string fmt(input logic [W+3:0] v);
        return $sformatf("cnt=%0d dir=%b z=%b p=%b m=%b", v[W+3:4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_dir   = 1'b0;
        m_mode  = CARRIER_UP;
        m_armed = 1'b0;
        m_psc   = 0;
    endtask

    // Drive this cycle's inputs and derive the expected outputs from the model state.
    task automatic predict();
        bit zsel, psel;
        bus.pwm_onoff    = drv_on;
        bus.carrier_mode = drv_cm;
        bus.mask_mode    = drv_mm;
        bus.period       = sh_out[W-1:0];
`ifdef PWM_MASK_PRESCALE_EN
        bus.mask_prescale = drv_psc[3:0];
`endif
        #1;
        zsel   = (drv_mm == MASK_ZERO)   || (drv_mm == MASK_BOTH);
        psel   = (drv_mm == MASK_PERIOD) || (drv_mm == MASK_BOTH);
        e_run  = (drv_on == PWM_ON) && m_armed;
        e_zero = e_run && (m_count == 0);
        e_per  = e_run && (m_count >= sh_out);
        e_qual = (zsel && e_zero) || (psel && e_per);
`ifdef PWM_MASK_PRESCALE_EN
        e_mask = e_qual && (m_psc == drv_psc);
`else
        e_mask = e_qual;
`endif
        e_vec = {m_count[W-1:0], m_dir, e_zero, e_per, e_mask};
    endtask

    // Apply the carrier rules for one clock edge, then move to the next negedge.
    task automatic advance();
        if (!e_run) begin
            m_mode  = drv_cm;
            m_dir   = (drv_cm == CARRIER_DOWN);
            m_count = m_dir ? sh_out : 0;
            m_psc   = 0;
        end else begin
            if (e_qual) m_psc = e_mask ? 0 : (m_psc + 1) % 16;
            case (m_mode)
                CARRIER_DOWN:
                    m_count = (m_count == 0) ? sh_out : m_count - 1;
                CARRIER_UPDOWN:
                    if (!m_dir) begin
                        if (m_count >= sh_out) begin
                            m_dir   = 1'b1;
                            m_count = (sh_out == 0) ? 0 : sh_out - 1;
                        end else m_count = m_count + 1;
                    end else begin
                        if (m_count == 0) begin
                            m_dir   = 1'b0;
                            m_count = (sh_out == 0) ? 0 : 1;
                        end else m_count = m_count - 1;
                    end
                default:
                    m_count = (m_count >= sh_out) ? 0 : m_count + 1;
            endcase
        end
        if (drv_on == PWM_OFF || e_mask) sh_out = sh_wr;
        m_armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drv_on = PWM_ON; drv_cm = CARRIER_DOWN; drv_mm = MASK_BOTH; sh_out = 5; sh_wr = 5;
        bus.pwm_onoff = drv_on; bus.carrier_mode = drv_cm; bus.mask_mode = drv_mm;
        bus.period = sh_out[W-1:0];
`ifdef PWM_MASK_PRESCALE_EN
        bus.mask_prescale = 4'd0;
`endif
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (got_vec() !== '0) begin
            n_fail++; $display("FAIL reset_async: got %s, exp all zero", fmt(got_vec()));
        end
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (got_vec() !== '0) begin
            n_fail++; $display("FAIL reset_held: got %s, exp all zero", fmt(got_vec()));
        end
        drv_on = PWM_OFF;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_up4();
        drv_cm = CARRIER_UP; drv_mm = MASK_PERIOD; sh_wr = 4; drv_on = PWM_OFF;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) drv_on = PWM_ON;
            predict();
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL up4 cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            if (i >= 2) begin
                automatic int ph = (i - 2) % 5;
                n_tests++;
                if ({bus.count, bus.zero_evt, bus.period_evt, bus.maskevent} !==
                    {W'(ph), ph == 0, ph == 4, ph == 4}) begin
                    n_fail++;
                    $display("FAIL up4_seq cyc %0d: got %s, exp cnt=%0d z=%b p=%b m=%b",
                             i, fmt(got_vec()), ph, ph == 0, ph == 4, ph == 4);
                end
            end
            advance();
        end
    endtask

    task automatic test_updown3();
        int cnt_t[10] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
        bit dir_t[10] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        drv_cm = CARRIER_UPDOWN; drv_mm = MASK_BOTH; sh_wr = 3; drv_on = PWM_OFF;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) drv_on = PWM_ON;
            predict();
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL updown3 cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            if (i >= 2) begin
                automatic int c = cnt_t[i-2];
                n_tests++;
                if ({bus.count, bus.dir_down, bus.maskevent} !== {W'(c), dir_t[i-2], (c == 0) || (c == 3)}) begin
                    n_fail++;
                    $display("FAIL updown3_seq cyc %0d: got %s, exp cnt=%0d dir=%b m=%b",
                             i, fmt(got_vec()), c, dir_t[i-2], (c == 0) || (c == 3));
                end
            end
            advance();
        end
    endtask

    task automatic test_down_shadow();
        drv_cm = CARRIER_DOWN; drv_mm = MASK_ZERO; sh_wr = 5; drv_on = PWM_OFF;
        for (int i = 0; i < 26; i++) begin
            if (i == 2) drv_on = PWM_ON;
            if (i == 4) sh_wr = 2;
            predict();
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL down_shadow cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            if (i == 2) begin
                n_tests++;
                if (bus.count !== W'(5) || bus.dir_down !== 1'b1) begin
                    n_fail++; $display("FAIL down_preset: got %s, exp cnt=5 dir=1", fmt(got_vec()));
                end
            end
            advance();
        end
    endtask

    task automatic test_period_zero();
        for (int md = 0; md < 3; md++) begin
            drv_cm = _carrier_mode'(md); drv_mm = _mask_mode'($urandom_range(0, 3));
            sh_wr = 0; drv_on = PWM_OFF;
            for (int i = 0; i < 8; i++) begin
                if (i == 2) drv_on = PWM_ON;
                predict();
                n_tests++;
                if (got_vec() !== e_vec) begin
                    n_fail++; $display("FAIL pzero m%0d cyc %0d: got %s, exp %s", md, i, fmt(got_vec()), fmt(e_vec));
                end
                if (i >= 2) begin
                    n_tests++;
                    if ({bus.count, bus.zero_evt, bus.period_evt} !== {W'(0), 1'b1, 1'b1}) begin
                        n_fail++; $display("FAIL pzero_evts m%0d cyc %0d: got %s, exp cnt=0 z=1 p=1", md, i, fmt(got_vec()));
                    end
                end
                advance();
            end
        end
    endtask

    task automatic test_period_drop();
        drv_cm = CARRIER_UP; drv_mm = MASK_NONE; sh_wr = 20; drv_on = PWM_OFF;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) drv_on = PWM_ON;
            if (i == 9) begin sh_out = 3; sh_wr = 3; end
            predict();
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL pdrop cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            if (i == 9 || i == 10) begin
                n_tests++;
                if ({bus.count, bus.period_evt, bus.maskevent} !== {(i == 9) ? W'(7) : W'(0), i == 9, 1'b0}) begin
                    n_fail++; $display("FAIL pdrop_term cyc %0d: got %s", i, fmt(got_vec()));
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_midrun();
        drv_cm = CARRIER_UP; drv_mm = MASK_BOTH; sh_wr = 30; drv_on = PWM_OFF;
        for (int i = 0; i < 11; i++) begin
            if (i == 2) drv_on = PWM_ON;
            predict();
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL midrun cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            advance();
        end
        n_tests++;
        if (bus.count !== W'(9)) begin
            n_fail++; $display("FAIL midrun_pre: got cnt=%0d, exp 9", bus.count);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (got_vec() !== '0) begin
            n_fail++; $display("FAIL midrun_async: got %s, exp all zero", fmt(got_vec()));
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            predict();
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL postreset cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            advance();
        end
    endtask

    task automatic test_mode_freeze();
        drv_cm = CARRIER_UP; drv_mm = MASK_BOTH; sh_wr = 6; drv_on = PWM_OFF;
        for (int i = 0; i < 26; i++) begin
            if (i == 2 || i == 16) drv_on = PWM_ON;
            if (i == 5) drv_cm = CARRIER_DOWN;
            if (i == 14) drv_on = PWM_OFF;
            predict();
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL freeze cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            if (i == 13 || i == 16) begin
                n_tests++;
                if (bus.dir_down !== (i == 16)) begin
                    n_fail++; $display("FAIL freeze_dir cyc %0d: got dir=%b", i, bus.dir_down);
                end
            end
            advance();
        end
    endtask

`ifdef PWM_MASK_PRESCALE_EN
    task automatic test_prescale();
        int k = 0;
        drv_cm = CARRIER_UP; drv_mm = MASK_PERIOD; sh_wr = 2; drv_psc = 2; drv_on = PWM_OFF;
        for (int i = 0; i < 24; i++) begin
            if (i == 2) drv_on = PWM_ON;
            predict();
            if (e_per) k++;
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL prescale cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            n_tests++;
            if (bus.maskevent !== (e_per && (k % 3 == 0))) begin
                n_fail++; $display("FAIL prescale_third cyc %0d: got m=%b, exp %b", i, bus.maskevent, e_per && (k % 3 == 0));
            end
            advance();
        end
        drv_psc = 0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) drv_on = (drv_on == PWM_ON) ? PWM_OFF : PWM_ON;
            drv_cm = _carrier_mode'($urandom_range(0, 2));
            if ($urandom_range(0, 29) == 0) drv_mm = _mask_mode'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) sh_wr = $urandom_range(0, 9);
            if ($urandom_range(0, 99) == 0) drv_psc = $urandom_range(0, 3);
            predict();
            n_tests++;
            if (got_vec() !== e_vec) begin
                n_fail++; $display("FAIL random cyc %0d: got %s, exp %s", i, fmt(got_vec()), fmt(e_vec));
            end
            advance();
        end
    endtask

    initial begin
        drv_on = PWM_OFF; drv_cm = CARRIER_UP; drv_mm = MASK_NONE; drv_psc = 0;
        sh_out = 0; sh_wr = 0;
        model_reset();
        test_reset();
        test_up4();
        test_updown3();
        test_down_shadow();
        test_period_zero();
        test_period_drop();
        test_reset_midrun();
        test_mode_freeze();
`ifdef PWM_MASK_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
